// File: rtl/string_hw_pkg.sv
// Shared types and constants for the String_HW engine arbiter.
package string_hw_pkg;

   // Default number of 32-bit words per string operand (must match the engine build)
   localparam int unsigned MAX_BLOCKS    = 2;
   localparam int unsigned MAX_LEN_BYTES = 4 * MAX_BLOCKS;

   typedef logic [MAX_BLOCKS-1:0][31:0] block_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP,
      DRAIN
   } arb_state_e;

   // A length is serviceable when it is non-zero and fits in the operand words
   function automatic logic length_ok(input logic [7:0] len, input int unsigned max_bytes);
      return (len != 8'd0) && (32'(len) <= max_bytes);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after the pointer, wrapping.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] id
);

   localparam int unsigned ID_W = $clog2(N);

   logic [ID_W-1:0] idx;
   logic            found;

   // Scan requesters starting from the pointer and take the first one pending
   always_comb begin
      grant = '0;
      id    = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = ID_W'((32'(ptr) + i) % N);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            id         = idx;
         end
      end
   end

endmodule

// File: rtl/string_hw_arbiter.sv
// Shares one String_HW engine among NUM_REQ requesters: round-robin grant,
// operand capture, go/done sequencing with timeout, tagged shared response.
module string_hw_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned MAX_BLOCKS     = string_hw_pkg::MAX_BLOCKS,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_REQ-1:0]                     req_valid,
   output logic [NUM_REQ-1:0]                     req_ready,
   input  logic [NUM_REQ-1:0][3:0]                req_index,
   input  logic [NUM_REQ-1:0][7:0]                req_length,
   input  logic [NUM_REQ-1:0][MAX_BLOCKS-1:0][31:0] req_A,
   input  logic [NUM_REQ-1:0][MAX_BLOCKS-1:0][31:0] req_B,
   output logic                                   rsp_valid,
   input  logic                                   rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]             rsp_id,
   output logic [MAX_BLOCKS-1:0][31:0]            rsp_result,
   output logic                                   rsp_err,
   output logic                                   rsp_timeout,
   output logic                                   eng_go,
   output logic [3:0]                             eng_index,
   output logic [7:0]                             eng_length,
   output logic [MAX_BLOCKS-1:0][31:0]            eng_A,
   output logic [MAX_BLOCKS-1:0][31:0]            eng_B,
   input  logic                                   eng_done,
   input  logic [MAX_BLOCKS-1:0][31:0]            eng_result,
   output logic                                   busy
);

   import string_hw_pkg::*;

   localparam int unsigned ID_W    = $clog2(NUM_REQ);
   localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned MAX_LEN = 4 * MAX_BLOCKS;

   arb_state_e       state;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  grant_id;
   logic [ID_W-1:0]  next_ptr;
   logic [NUM_REQ-1:0] grant;
   logic [CNT_W-1:0] cnt;
   logic             cnt_last;
   logic             handshake;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .id    (grant_id)
   );

   // Grants are only offered while idle; held off entirely during reset
   assign req_ready = (state == IDLE && !reset) ? grant : '0;
   assign handshake = |(req_valid & req_ready);
   assign cnt_last  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

   // Arbiter FSM with capture, timeout counter and registered response
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         eng_go      <= 1'b0;
         eng_index   <= '0;
         eng_length  <= '0;
         eng_A       <= '0;
         eng_B       <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_result  <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (handshake) begin
                  eng_index  <= req_index[grant_id];
                  eng_length <= req_length[grant_id];
                  eng_A      <= req_A[grant_id];
                  eng_B      <= req_B[grant_id];
                  rsp_id     <= grant_id;
                  rr_ptr     <= next_ptr;
                  cnt        <= '0;
                  busy       <= 1'b1;
                  if (length_ok(req_length[grant_id], MAX_LEN)) begin
                     state  <= WAIT;
                     eng_go <= 1'b1;
                  end else begin
                     // Bad length is answered directly without touching the engine
                     state       <= RESP;
                     rsp_valid   <= 1'b1;
                     rsp_err     <= 1'b1;
                     rsp_timeout <= 1'b0;
                     rsp_result  <= '0;
                  end
               end
            end

            WAIT: begin
               if (eng_done) begin
                  // Done takes priority over a timeout landing in the same cycle
                  state       <= RESP;
                  eng_go      <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_result  <= eng_result;
                  rsp_err     <= 1'b0;
                  rsp_timeout <= 1'b0;
               end else if (cnt_last) begin
                  state       <= RESP;
                  eng_go      <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_result  <= '0;
                  rsp_err     <= 1'b0;
                  rsp_timeout <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cnt       <= '0;
                  if (!eng_done) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               // Wait for the engine to drop done, but never hang on a stuck engine
               if (!eng_done || cnt_last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               eng_go    <= 1'b0;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_string_hw_arbiter.sv
// Self-checking bench for string_hw_arbiter with a behavioural requester/engine model.
module tb_string_hw_arbiter;

   localparam int NR = 4;
   localparam int MB = 2;
   localparam int TO = 16;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [NR-1:0]             req_valid;
   logic [NR-1:0]             req_ready;
   logic [NR-1:0][3:0]        req_index;
   logic [NR-1:0][7:0]        req_length;
   logic [NR-1:0][MB-1:0][31:0] req_A;
   logic [NR-1:0][MB-1:0][31:0] req_B;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [1:0]                rsp_id;
   logic [MB-1:0][31:0]       rsp_result;
   logic                      rsp_err;
   logic                      rsp_timeout;
   logic                      eng_go;
   logic [3:0]                eng_index;
   logic [7:0]                eng_length;
   logic [MB-1:0][31:0]       eng_A;
   logic [MB-1:0][31:0]       eng_B;
   logic                      eng_done;
   logic [MB-1:0][31:0]       eng_result;
   logic                      busy;

   int checks = 0;
   int errors = 0;
   int exp_ptr = 0;

   string_hw_arbiter #(
      .NUM_REQ        (NR),
      .MAX_BLOCKS     (MB),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_index   (req_index),
      .req_length  (req_length),
      .req_A       (req_A),
      .req_B       (req_B),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_result  (rsp_result),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .eng_go      (eng_go),
      .eng_index   (eng_index),
      .eng_length  (eng_length),
      .eng_A       (eng_A),
      .eng_B       (eng_B),
      .eng_done    (eng_done),
      .eng_result  (eng_result),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference round-robin: first pending requester at or after the pointer
   function automatic int model_grant(input logic [NR-1:0] v, input int p);
      int k;
      for (int i = 0; i < NR; i++) begin
         k = (p + i) % NR;
         if (v[k[1:0]]) return k;
      end
      return -1;
   endfunction

   function automatic logic [NR-1:0] onehot(input int g);
      return (g < 0) ? 4'b0000 : 4'(1 << g);
   endfunction

   function automatic logic [68:0] rsp_obs();
      return {rsp_valid, rsp_id, rsp_err, rsp_timeout, rsp_result};
   endfunction

   function automatic logic [68:0] rsp_exp(input int id, input logic err, input logic tmo,
                                           input logic [MB-1:0][31:0] res);
      return {1'b1, 2'(id), err, tmo, res};
   endfunction

   task automatic randomize_reqs(input int min_len, input int max_len);
      for (int r = 0; r < NR; r++) begin
         req_index[r]  = 4'($urandom_range(0, 15));
         req_length[r] = 8'($urandom_range(min_len, max_len));
         for (int b = 0; b < MB; b++) begin
            req_A[r][b] = $urandom;
            req_B[r][b] = $urandom;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = '1;
      cyc();
      cyc();
      checks++;
      if ({req_ready, rsp_valid, eng_go, busy, rsp_err, rsp_timeout} !== 9'd0)
         begin errors++; $display("FAIL reset_ctrl: got %b expected 0",
                                  {req_ready, rsp_valid, eng_go, busy, rsp_err, rsp_timeout}); end
      checks++;
      if ({eng_index, eng_length, eng_A, eng_B, rsp_result, rsp_id} !== '0)
         begin errors++; $display("FAIL reset_data: got %h expected 0",
                                  {eng_index, eng_length, eng_A, eng_B, rsp_result, rsp_id}); end
      reset = 1'b0;
      req_valid = '0;
      exp_ptr = 0;
      cyc();
      checks++;
      if (req_ready !== 4'b0000 || busy !== 1'b0)
         begin errors++; $display("FAIL idle_no_req: got ready=%b busy=%b expected 0000/0", req_ready, busy); end
   endtask

   task automatic test_single();
      logic [MB-1:0][31:0] r;
      int n;
      req_index[1]  = 4'd6;
      req_length[1] = 8'd5;
      req_A[1][0]   = 32'h61626364;
      req_A[1][1]   = 32'h65000000;
      req_B[1][0]   = 32'h61626378;
      req_B[1][1]   = 32'h65000000;
      req_valid     = 4'b0010;
      #1;
      checks++;
      if (req_ready !== onehot(model_grant(req_valid, exp_ptr)))
         begin errors++; $display("FAIL single_grant: got %b expected %b", req_ready, onehot(model_grant(req_valid, exp_ptr))); end
      cyc();
      req_valid = '0;
      exp_ptr = 2;
      checks++;
      if ({eng_go, busy, eng_index, eng_length, eng_A, eng_B} !== {2'b11, req_index[1], req_length[1], req_A[1], req_B[1]})
         begin errors++; $display("FAIL single_capture: got %h expected %h", {eng_go, busy, eng_index, eng_length, eng_A, eng_B},
                                  {2'b11, req_index[1], req_length[1], req_A[1], req_B[1]}); end
      r = {$urandom, $urandom};
      n = 0;
      while (eng_go === 1'b1 && n < TO + 4) begin
         n++;
         if (n == 3) begin eng_done = 1'b1; eng_result = r; end
         cyc();
      end
      checks++;
      if (n !== 3) begin errors++; $display("FAIL single_go_cycles: got %0d expected 3", n); end
      checks++;
      if (rsp_obs() !== rsp_exp(1, 1'b0, 1'b0, r))
         begin errors++; $display("FAIL single_rsp: got %h expected %h", rsp_obs(), rsp_exp(1, 1'b0, 1'b0, r)); end
      eng_done = 1'b0;
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      checks++;
      if ({rsp_valid, busy} !== 2'b00)
         begin errors++; $display("FAIL single_accept: got %b expected 00", {rsp_valid, busy}); end
   endtask

   task automatic test_errors();
      logic [7:0] bad [2];
      bad[0] = 8'd0;
      bad[1] = 8'd9;
      for (int t = 0; t < 2; t++) begin
         req_length[2] = bad[t];
         req_valid = 4'b0100;
         #1;
         checks++;
         if (req_ready !== onehot(model_grant(req_valid, exp_ptr)))
            begin errors++; $display("FAIL err_grant: got %b expected %b", req_ready, onehot(model_grant(req_valid, exp_ptr))); end
         cyc();
         req_valid = '0;
         exp_ptr = 3;
         checks++;
         if ({eng_go, rsp_obs()} !== {1'b0, rsp_exp(2, 1'b1, 1'b0, '0)})
            begin errors++; $display("FAIL err_rsp len=%0d: got %h expected %h", bad[t], {eng_go, rsp_obs()},
                                     {1'b0, rsp_exp(2, 1'b1, 1'b0, '0)}); end
         cyc();
         checks++;
         if ({eng_go, rsp_obs()} !== {1'b0, rsp_exp(2, 1'b1, 1'b0, '0)})
            begin errors++; $display("FAIL err_hold len=%0d: got %h", bad[t], {eng_go, rsp_obs()}); end
         rsp_ready = 1'b1;
         cyc();
         rsp_ready = 1'b0;
         checks++;
         if ({eng_go, rsp_valid, busy} !== 3'b000)
            begin errors++; $display("FAIL err_accept: got %b expected 000", {eng_go, rsp_valid, busy}); end
      end
   endtask

   task automatic test_timeout();
      logic [MB-1:0][31:0] r;
      int n;
      // Engine never answers
      req_length[0] = 8'd4;
      req_valid = 4'b0001;
      cyc();
      req_valid = '0;
      exp_ptr = 1;
      n = 0;
      while (eng_go === 1'b1 && n < 3 * TO) begin n++; cyc(); end
      checks++;
      if (n !== TO) begin errors++; $display("FAIL timeout_go_cycles: got %0d expected %0d", n, TO); end
      checks++;
      if (rsp_obs() !== rsp_exp(0, 1'b0, 1'b1, '0))
         begin errors++; $display("FAIL timeout_rsp: got %h expected %h", rsp_obs(), rsp_exp(0, 1'b0, 1'b1, '0)); end
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      // Done arrives in the very last allowed cycle: done wins
      req_length[3] = 8'd8;
      req_valid = 4'b1000;
      cyc();
      req_valid = '0;
      exp_ptr = 0;
      r = {$urandom, $urandom};
      n = 0;
      while (eng_go === 1'b1 && n < 3 * TO) begin
         n++;
         if (n == TO) begin eng_done = 1'b1; eng_result = r; end
         cyc();
      end
      eng_done = 1'b0;
      checks++;
      if (n !== TO) begin errors++; $display("FAIL tie_go_cycles: got %0d expected %0d", n, TO); end
      checks++;
      if (rsp_obs() !== rsp_exp(3, 1'b0, 1'b0, r))
         begin errors++; $display("FAIL tie_rsp: got %h expected %h", rsp_obs(), rsp_exp(3, 1'b0, 1'b0, r)); end
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
   endtask

   task automatic test_drain();
      logic [MB-1:0][31:0] r;
      int n;
      req_length[1] = 8'd3;
      req_valid = 4'b0010;
      cyc();
      req_valid = '0;
      exp_ptr = 2;
      r = {$urandom, $urandom};
      eng_done = 1'b1;
      eng_result = r;
      cyc();
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({eng_go, rsp_obs()} !== {1'b0, rsp_exp(1, 1'b0, 1'b0, r)})
            begin errors++; $display("FAIL drain_hold cyc=%0d: got %h expected %h", i, {eng_go, rsp_obs()},
                                     {1'b0, rsp_exp(1, 1'b0, 1'b0, r)}); end
         eng_result = {$urandom, $urandom};
         cyc();
      end
      req_valid = 4'b1000;
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({rsp_valid, eng_go, busy, req_ready} !== {3'b001, 4'b0000})
            begin errors++; $display("FAIL drain_state cyc=%0d: got %b expected 0010000", i, {rsp_valid, eng_go, busy, req_ready}); end
         cyc();
      end
      eng_done = 1'b0;
      cyc();
      checks++;
      if ({busy, req_ready} !== {1'b0, onehot(model_grant(req_valid, exp_ptr))})
         begin errors++; $display("FAIL drain_exit: got %b expected %b", {busy, req_ready},
                                  {1'b0, onehot(model_grant(req_valid, exp_ptr))}); end
      req_valid = '0;
      // Engine holds done forever: drain must give up after the bound
      req_length[2] = 8'd1;
      req_valid = 4'b0100;
      cyc();
      req_valid = '0;
      exp_ptr = 3;
      eng_done = 1'b1;
      cyc();
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 3 * TO) begin n++; cyc(); end
      eng_done = 1'b0;
      checks++;
      if (n !== TO) begin errors++; $display("FAIL drain_bound: got %0d expected %0d", n, TO); end
   endtask

   task automatic test_reset_mid_wait();
      req_length[2] = 8'd2;
      req_valid = 4'b0100;
      cyc();
      req_valid = '0;
      cyc();
      reset = 1'b1;
      #1;
      checks++;
      if ({eng_go, rsp_valid, busy} !== 3'b000)
         begin errors++; $display("FAIL reset_mid_wait: got %b expected 000", {eng_go, rsp_valid, busy}); end
      cyc();
      reset = 1'b0;
      exp_ptr = 0;
      req_valid = 4'b1111;
      #1;
      checks++;
      if (req_ready !== 4'b0001)
         begin errors++; $display("FAIL reset_ptr: got %b expected 0001", req_ready); end
   endtask

   task automatic test_round_robin();
      int order [5] = '{0, 1, 2, 3, 0};
      logic [MB-1:0][31:0] r;
      int g;
      randomize_reqs(1, 8);
      req_valid = 4'b1111;
      #1;
      for (int t = 0; t < 5; t++) begin
         g = model_grant(req_valid, exp_ptr);
         checks++;
         if (g !== order[t] || req_ready !== onehot(order[t]))
            begin errors++; $display("FAIL rr_grant t=%0d: got %b expected %b", t, req_ready, onehot(order[t])); end
         cyc();
         exp_ptr = (g + 1) % NR;
         checks++;
         if ({eng_go, eng_A, eng_B} !== {1'b1, req_A[g], req_B[g]})
            begin errors++; $display("FAIL rr_capture t=%0d: got %h expected %h", t, {eng_go, eng_A, eng_B}, {1'b1, req_A[g], req_B[g]}); end
         r = {$urandom, $urandom};
         eng_done = 1'b1;
         eng_result = r;
         cyc();
         eng_done = 1'b0;
         checks++;
         if (rsp_obs() !== rsp_exp(g, 1'b0, 1'b0, r))
            begin errors++; $display("FAIL rr_rsp t=%0d: got %h expected %h", t, rsp_obs(), rsp_exp(g, 1'b0, 1'b0, r)); end
         rsp_ready = 1'b1;
         cyc();
         rsp_ready = 1'b0;
      end
      req_valid = '0;
      cyc();
   endtask

   task automatic test_random();
      logic [MB-1:0][31:0] r;
      logic [MB-1:0][31:0] exp_res;
      logic err, tmo;
      int g, lat, n, d;
      for (int t = 0; t < 40; t++) begin
         randomize_reqs(0, 10);
         req_valid = 4'($urandom_range(1, 15));
         #1;
         g = model_grant(req_valid, exp_ptr);
         checks++;
         if (req_ready !== onehot(g))
            begin errors++; $display("FAIL rnd_grant t=%0d: got %b expected %b", t, req_ready, onehot(g)); end
         cyc();
         req_valid = '0;
         exp_ptr = (g + 1) % NR;
         err = (req_length[g] == 8'd0) || (req_length[g] > 8'(4 * MB));
         checks++;
         if ({eng_index, eng_length, eng_A, eng_B} !== {req_index[g], req_length[g], req_A[g], req_B[g]})
            begin errors++; $display("FAIL rnd_capture t=%0d: got %h", t, {eng_index, eng_length, eng_A, eng_B}); end
         tmo = 1'b0;
         exp_res = '0;
         if (!err) begin
            lat = $urandom_range(1, TO + 2);
            r = {$urandom, $urandom};
            tmo = (lat > TO);
            exp_res = tmo ? '0 : r;
            n = 0;
            while (eng_go === 1'b1 && n < 3 * TO) begin
               n++;
               if (n == lat) begin eng_done = 1'b1; eng_result = r; end
               cyc();
            end
            eng_done = 1'b0;
            checks++;
            if (n !== (tmo ? TO : lat))
               begin errors++; $display("FAIL rnd_go_cycles t=%0d: got %0d expected %0d", t, n, tmo ? TO : lat); end
         end
         d = $urandom_range(0, 3);
         for (int i = 0; i <= d; i++) begin
            checks++;
            if ({eng_go, rsp_obs()} !== {1'b0, rsp_exp(g, err, tmo, exp_res)})
               begin errors++; $display("FAIL rnd_rsp t=%0d: got %h expected %h", t, {eng_go, rsp_obs()},
                                        {1'b0, rsp_exp(g, err, tmo, exp_res)}); end
            if (i < d) cyc();
         end
         rsp_ready = 1'b1;
         cyc();
         rsp_ready = 1'b0;
         checks++;
         if ({rsp_valid, busy} !== 2'b00)
            begin errors++; $display("FAIL rnd_accept t=%0d: got %b expected 00", t, {rsp_valid, busy}); end
      end
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = '0;
      req_index  = '0;
      req_length = '0;
      req_A      = '0;
      req_B      = '0;
      rsp_ready  = 1'b0;
      eng_done   = 1'b0;
      eng_result = '0;
      test_reset();
      test_single();
      test_errors();
      test_timeout();
      test_drain();
      test_reset_mid_wait();
      test_round_robin();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
